// File: rtl/tt_io_vector_driver.sv
// tt_io_vector_driver
// Host-side vector driver for a tt_um_* tile's dedicated pins. It buffers
// {stimulus, expected, mask} vectors and replays them on the tile's input
// bus. After each update it waits SETTLE cycles, samples the tile's output
// bus and compares it under the mask. It reports the mismatch count, the
// first failing index and pass/fail.
//
// Parameters
//   DEPTH  : vector buffer entries (power of two, >= 2)
//   SETTLE : cycles from a dut_in update to the dut_out sample (>= 1)
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   vec_valid/vec_ready       : vector write handshake (IDLE only)
//   vec_stim/vec_exp/vec_mask : vector contents (mask bit 1 = bit checked)
//   start                     : single-cycle run request
//   busy, done                : run in progress / one-cycle end-of-run pulse
//   pass, err_count           : result of the last run (err_count saturates)
//   first_err_valid/_idx      : index of the first mismatching vector
//   dut_in, dut_out           : registered drive to ui_in, sampled uo_out
//
// Optional build macro
//   TT_VECTOR_HALT_ON_ERR_EN : when defined, the first mismatch ends the run.
module tt_io_vector_driver #(
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic [7:0]               vec_stim,
    input  logic [7:0]               vec_exp,
    input  logic [7:0]               vec_mask,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               err_count,
    output logic                     first_err_valid,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [7:0]               dut_in,
    input  logic [7:0]               dut_out
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_stim [DEPTH];
    logic [7:0]      r_exp  [DEPTH];
    logic [7:0]      r_mask [DEPTH];

    logic [CW-1:0]   r_count;
    logic [IW-1:0]   r_idx;
    logic [SW-1:0]   r_settle;
    logic [7:0]      r_err;
    logic            r_pass;
    logic            r_fev;
    logic [IW-1:0]   r_fei;
    logic [7:0]      r_dut_in;

    logic            w_wr;
    logic            w_expire;
    logic            w_mis;
    logic            w_last;
    logic            w_stop;
    logic [7:0]      w_err_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
        if (inc && (c != 8'hFF))
            return c + 8'd1;
        return c;
    endfunction

    // start takes priority over a simultaneous write request.
    assign w_wr      = vec_valid && vec_ready && !start;
    assign w_expire  = (r_state == S_RUN) && (r_settle == '0);
    assign w_mis     = |((dut_out ^ r_exp[r_idx]) & r_mask[r_idx]);
    assign w_last    = ({1'b0, r_idx} == (r_count - 1'b1));
    assign w_err_nxt = sat_inc(r_err, w_mis);

`ifdef TT_VECTOR_HALT_ON_ERR_EN
    assign w_stop = w_last || w_mis;
`else
    assign w_stop = w_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        vec_ready   = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
        busy        = (r_state == S_RUN);
        done        = (r_state == S_FIN);
        case (r_state)
            S_IDLE: if (start) w_state_nxt = (r_count != '0) ? S_RUN : S_FIN;
            S_RUN:  if (w_expire && w_stop) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Buffer storage carries no reset; r_count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_stim[r_count[IW-1:0]] <= vec_stim;
            r_exp[r_count[IW-1:0]]  <= vec_exp;
            r_mask[r_count[IW-1:0]] <= vec_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_idx    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
            r_fev    <= 1'b0;
            r_fei    <= '0;
            r_dut_in <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err    <= '0;
                        r_fev    <= 1'b0;
                        r_fei    <= '0;
                        r_idx    <= '0;
                        r_settle <= SW'(SETTLE - 1);
                        if (r_count != '0) begin
                            r_pass   <= 1'b0;
                            r_dut_in <= r_stim[0];
                        end else begin
                            // Empty run: trivially passes.
                            r_pass <= 1'b1;
                        end
                    end else if (w_wr) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else begin
                        r_err <= w_err_nxt;
                        if (w_mis && !r_fev) begin
                            r_fev <= 1'b1;
                            r_fei <= r_idx;
                        end
                        if (w_stop) begin
                            // Result is valid in the FIN cycle alongside done.
                            r_pass <= (w_err_nxt == 8'd0);
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_dut_in <= r_stim[r_idx + 1'b1];
                            r_settle <= SW'(SETTLE - 1);
                        end
                    end
                end
                S_FIN: r_count <= '0;
                default: ;
            endcase
        end
    end

    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;
    assign dut_in          = r_dut_in;

endmodule
